// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier.
// Drives a registered write-back port into the register file.
module exec_unit #(
   parameter int D_BITS  = 32,
   parameter int SH_BITS = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        opcode,
   input  logic [D_BITS-1:0] op0,
   input  logic [D_BITS-1:0] op1,
   input  logic [2:0]        dst,
   output logic              wb_we,
   output logic [2:0]        wb_addr,
   output logic [D_BITS-1:0] wb_data,
   output logic              busy
);

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_e;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;

   localparam logic [SH_BITS-1:0] CNT_LAST = SH_BITS'(D_BITS - 1);

   state_e              state_q, state_d;
   logic [D_BITS-1:0]   acc_q, acc_d;
   logic [D_BITS-1:0]   mcand_q, mcand_d;
   logic [D_BITS-1:0]   mplier_q, mplier_d;
   logic [SH_BITS-1:0]  cnt_q, cnt_d;
   logic [2:0]          dst_q, dst_d;
   logic                wb_we_q, wb_we_d;
   logic [2:0]          wb_addr_q, wb_addr_d;
   logic [D_BITS-1:0]   wb_data_q, wb_data_d;

   logic [D_BITS-1:0]   alu_res;
   logic [D_BITS-1:0]   acc_next;
   logic [SH_BITS-1:0]  shamt;
   logic                is_nop;
   logic                accept;

   assign in_ready = (state_q == S_IDLE);
   assign busy     = (state_q == S_MUL);
   assign accept   = in_valid & in_ready;
   assign shamt    = op1[SH_BITS-1:0];
   assign is_nop   = (opcode > OP_MUL);
   assign wb_we    = wb_we_q;
   assign wb_addr  = wb_addr_q;
   assign wb_data  = wb_data_q;

   always_comb begin
      alu_res = '0;
      unique case (opcode)
         OP_ADD:  alu_res = op0 + op1;
         OP_SUB:  alu_res = op0 - op1;
         OP_AND:  alu_res = op0 & op1;
         OP_OR:   alu_res = op0 | op1;
         OP_XOR:  alu_res = op0 ^ op1;
         OP_SLL:  alu_res = op0 << shamt;
         OP_SRL:  alu_res = op0 >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(op0) >>> shamt);
         OP_SLT:  alu_res = {{(D_BITS-1){1'b0}}, ($signed(op0) < $signed(op1))};
         OP_SLTU: alu_res = {{(D_BITS-1){1'b0}}, (op0 < op1)};
         default: alu_res = '0;
      endcase
   end

   // The final partial product is folded in on the last edge, so the
   // write-back carries the complete product without an extra cycle.
   assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      dst_d     = dst_q;
      wb_we_d   = 1'b0;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (opcode == OP_MUL) begin
                  mcand_d  = op0;
                  mplier_d = op1;
                  dst_d    = dst;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = S_MUL;
               end else if (!is_nop) begin
                  wb_we_d   = 1'b1;
                  wb_addr_d = dst;
                  wb_data_d = alu_res;
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               wb_we_d   = 1'b1;
               wb_addr_d = dst_q;
               wb_data_d = acc_next;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         dst_q     <= '0;
         wb_we_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         dst_q     <= dst_d;
         wb_we_q   <= wb_we_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
      end
   end

endmodule
